// File: rtl/fdiv_seq.sv
// rtl/fdiv_seq.sv - sequential binary32 divider: restoring mantissa division, truncating rounding
module fdiv_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        inexact,
    output logic        invalid,
    output logic        divzero,
    output logic        overflow
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [25:0]        rem_q, rem_d;
    logic [23:0]        dvsr_q, dvsr_d;
    logic [24:0]        quo_q, quo_d;
    logic [4:0]         cnt_q, cnt_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic [31:0]        out_q, out_d;
    logic               inexact_q, inexact_d;
    logic               invalid_q, invalid_d;
    logic               divzero_q, divzero_d;
    logic               overflow_q, overflow_d;

    // Operand classification; exp==0 is treated as zero, so subnormals flush.
    logic zero1, zero2, inf1, inf2, nan1, nan2, snan1, snan2, special, sgn;
    assign zero1   = (in1[30:23] == 8'd0);
    assign zero2   = (in2[30:23] == 8'd0);
    assign inf1    = (in1[30:23] == 8'hFF) && (in1[22:0] == 23'd0);
    assign inf2    = (in2[30:23] == 8'hFF) && (in2[22:0] == 23'd0);
    assign nan1    = (in1[30:23] == 8'hFF) && (in1[22:0] != 23'd0);
    assign nan2    = (in2[30:23] == 8'hFF) && (in2[22:0] != 23'd0);
    assign snan1   = nan1 && !in1[22];
    assign snan2   = nan2 && !in2[22];
    assign special = zero1 | zero2 | (in1[30:23] == 8'hFF) | (in2[30:23] == 8'hFF);
    assign sgn     = in1[31] ^ in2[31];

    logic [31:0] spec_out;
    logic        spec_invalid, spec_divzero;

    always_comb begin
        spec_out     = {sgn, 31'd0};
        spec_invalid = 1'b0;
        spec_divzero = 1'b0;
        if (nan1 || nan2) begin
            spec_out     = 32'h7FC00000;
            spec_invalid = snan1 | snan2;
        end else if ((zero1 && zero2) || (inf1 && inf2)) begin
            spec_out     = 32'h7FC00000;
            spec_invalid = 1'b1;
        end else if (zero2 && !inf1) begin
            spec_out     = {sgn, 8'hFF, 23'd0};
            spec_divzero = 1'b1;
        end else if (inf1) begin
            spec_out     = {sgn, 8'hFF, 23'd0};
        end
    end

    logic               ge;
    logic [25:0]        diff;
    logic signed [9:0]  exp_n;
    logic [23:0]        mant;
    logic               lost;

    assign ge    = (rem_q >= {2'b00, dvsr_q});
    assign diff  = ge ? (rem_q - {2'b00, dvsr_q}) : rem_q;
    assign exp_n = quo_q[24] ? (exp_q + 10'sd127) : (exp_q + 10'sd126);
    assign mant  = quo_q[24] ? quo_q[24:1] : quo_q[23:0];
    assign lost  = (quo_q[24] && quo_q[0]) || (rem_q != 26'd0);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        out_d      = out_q;
        inexact_d  = inexact_q;
        invalid_d  = invalid_q;
        divzero_d  = divzero_q;
        overflow_d = overflow_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d     = sgn;
                    exp_d      = $signed({2'b00, in1[30:23]}) - $signed({2'b00, in2[30:23]});
                    rem_d      = {3'b001, in1[22:0]};
                    dvsr_d     = {1'b1, in2[22:0]};
                    quo_d      = 25'd0;
                    cnt_d      = 5'd0;
                    inexact_d  = 1'b0;
                    invalid_d  = 1'b0;
                    divzero_d  = 1'b0;
                    overflow_d = 1'b0;
                    if (special) begin
                        out_d     = spec_out;
                        invalid_d = spec_invalid;
                        divzero_d = spec_divzero;
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_DIV;
                    end
                end
            end
            S_DIV: begin
                // Remainder stays below 2*divisor, so the shifted value fits 26 bits.
                quo_d = {quo_q[23:0], ge};
                rem_d = {diff[24:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd24) state_d = S_NORM;
            end
            S_NORM: begin
                if (exp_n >= 10'sd255) begin
                    out_d      = {sign_q, 8'hFF, 23'd0};
                    overflow_d = 1'b1;
                    inexact_d  = 1'b1;
                end else if (exp_n <= 10'sd0) begin
                    out_d      = {sign_q, 31'd0};
                    inexact_d  = 1'b1;
                end else begin
                    out_d      = {sign_q, exp_n[7:0], mant[22:0]};
                    inexact_d  = lost;
                end
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            rem_q      <= 26'd0;
            dvsr_q     <= 24'd0;
            quo_q      <= 25'd0;
            cnt_q      <= 5'd0;
            exp_q      <= 10'sd0;
            sign_q     <= 1'b0;
            out_q      <= 32'd0;
            inexact_q  <= 1'b0;
            invalid_q  <= 1'b0;
            divzero_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            dvsr_q     <= dvsr_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            out_q      <= out_d;
            inexact_q  <= inexact_d;
            invalid_q  <= invalid_d;
            divzero_q  <= divzero_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign out      = out_q;
    assign inexact  = inexact_q;
    assign invalid  = invalid_q;
    assign divzero  = divzero_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// tb/tb_fdiv_seq.sv - randomized and directed self-checking bench for fdiv_seq
module tb_fdiv_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [31:0] in1, in2;
    logic        busy, done;
    logic [31:0] out;
    logic        inexact, invalid, divzero, overflow;

    fdiv_seq dut (
        .CLK(CLK), .RST(RST), .start(start), .in1(in1), .in2(in2),
        .busy(busy), .done(done), .out(out),
        .inexact(inexact), .invalid(invalid), .divzero(divzero), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] result_bus();
        return {out, inexact, invalid, divzero, overflow};
    endfunction

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'd0) || (b[30:23] == 8'd0) || (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    endfunction

    // Reference: exact integer quotient of scaled mantissas, then truncate.
    // Returned as {out, inexact, invalid, divzero, overflow}.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        int ea = int'(a[30:23]);
        int eb = int'(b[30:23]);
        bit s  = a[31] ^ b[31];
        bit za = (ea == 0), zb = (eb == 0);
        bit ia = (ea == 255) && (a[22:0] == 0), ib = (eb == 255) && (b[22:0] == 0);
        bit na = (ea == 255) && (a[22:0] != 0), nb = (eb == 255) && (b[22:0] != 0);
        bit sn = (na && !a[22]) || (nb && !b[22]);
        longint unsigned ma, mb, num, q, r, m;
        int e;
        bit lost;
        logic [31:0] res;
        if (na || nb) return {32'h7FC00000, 1'b0, sn, 2'b00};
        if ((za && zb) || (ia && ib)) return {32'h7FC00000, 4'b0100};
        if (zb && !ia) return {s, 8'hFF, 23'd0, 4'b0010};
        if (ia) return {s, 8'hFF, 23'd0, 4'b0000};
        if (za || ib) return {s, 31'd0, 4'b0000};
        ma  = {40'd0, 1'b1, a[22:0]};
        mb  = {40'd0, 1'b1, b[22:0]};
        num = ma << 24;
        q   = num / mb;
        r   = num % mb;
        e   = ea - eb + 127;
        if (q >= 64'h1000000) begin
            m    = q >> 1;
            lost = (q[0] != 1'b0);
        end else begin
            m    = q;
            lost = 1'b0;
            e    = e - 1;
        end
        lost = lost || (r != 0);
        if (e >= 255) return {s, 8'hFF, 23'd0, 4'b1001};
        if (e <= 0) return {s, 31'd0, 4'b1000};
        res = {s, e[7:0], m[22:0]};
        return {res, lost, 3'b000};
    endfunction

    function automatic logic [31:0] rand_fp();
        int r = $urandom_range(0, 15);
        logic [7:0]  e;
        logic [22:0] f = 23'($urandom);
        if (r == 0) e = 8'd0;
        else if (r == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 1) f = 23'd0;
        end else if (r < 8) e = 8'($urandom_range(100, 154));
        else e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, f};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [35:0] exp_r   = model(a, b);
        int          exp_lat = is_special(a, b) ? 1 : 27;
        int          lat     = 0;
        @(negedge CLK);
        in1 = a; in2 = b; start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0; in1 = $urandom; in2 = $urandom;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        for (int n = 1; n <= 40; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (poke && n == 5) start = 1'b1;
            if (poke && n == 6) start = 1'b0;
            @(negedge CLK);
        end
        start = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
        check("result", {28'd0, result_bus()}, {28'd0, exp_r});
        @(negedge CLK);
        check("done_pulse", {63'd0, done}, 64'd0);
        check("idle_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge CLK);
        check("hold", {28'd0, result_bus()}, {28'd0, exp_r});
    endtask

    initial begin
        int dones;
        RST = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
        repeat (3) @(negedge CLK);
        check("reset_state", {27'd0, busy, done, result_bus()}, 64'd0);
        // Reset dominates start in the same cycle.
        start = 1'b1; in1 = 32'h40C00000; in2 = 32'h40000000;
        @(negedge CLK);
        check("reset_beats_start", {62'd0, busy, done}, 64'd0);
        RST = 1'b0; start = 1'b0;

        run_op(32'h40C00000, 32'h40000000, 1'b0);
        run_op(32'h40C00000, 32'h40000000, 1'b1);
        run_op(32'h3F800000, 32'h40400000, 1'b0);
        run_op(32'h3F800000, 32'h00000000, 1'b0);
        run_op(32'h00000000, 32'h00000000, 1'b0);
        run_op(32'h7F000000, 32'h3E800000, 1'b0);
        run_op(32'h00800000, 32'h4B000000, 1'b0);
        run_op(32'h7FA00000, 32'h3F800000, 1'b0);
        run_op(32'h7FC00000, 32'h7F800000, 1'b0);
        run_op(32'hFF800000, 32'h7F800000, 1'b0);
        run_op(32'h7F800000, 32'h80000000, 1'b0);
        run_op(32'h80000000, 32'h7F800000, 1'b0);
        run_op(32'hBF800000, 32'h40400000, 1'b0);
        run_op(32'h3FFFFFFF, 32'h3F800001, 1'b0);

        // Abort mid-division with reset at edge k+10.
        @(negedge CLK);
        in1 = 32'h40C00000; in2 = 32'h40000000; start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        dones = 0;
        repeat (9) begin
            if (done) dones++;
            @(negedge CLK);
        end
        RST = 1'b1;
        @(negedge CLK);
        check("abort_state", {27'd0, busy, done, result_bus()}, 64'd0);
        RST = 1'b0;
        repeat (30) begin
            @(negedge CLK);
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        run_op(32'h40C00000, 32'h40000000, 1'b0);

        for (int i = 0; i < 40; i++) run_op(rand_fp(), rand_fp(), ($urandom_range(0, 3) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
